// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between one master and the ahb_mem_slave memory target.
// HREADY is the bus-level ready returned to all slaves; HREADYOUT/HRESP/HRDATA come back from the slave.
interface ahb_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [1:0]        HTRANS;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic [1:0]        HRESP;
    logic [DATA_W-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB memory slave: OKAY data phase WAIT_STATES+1 cycles after accept, two-cycle ERROR on bad access.
// Stalls via HREADYOUT; define AHB_MEM_SLAVE_ALIGN_CHK_EN to turn misaligned accesses into ERROR.
module ahb_mem_slave #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            resetn,
    ahb_mem_slave_if.slave  bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0] LO_ADDR = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] HI_ADDR = LO_ADDR + (ADDR_W+1)'(DEPTH * BYTES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t              r_state;
    logic [3:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [2:0]          r_size;
    logic                r_hreadyout;
    logic [1:0]          r_hresp;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_out_of_range;
    logic                w_bad_size;
    logic                w_err;
    logic [LANE_W-1:0]   w_lane_lo;
    logic [BYTES-1:0]    w_be;
    logic [IDX_W-1:0]    w_idx;
    logic                w_unused;

    // Gating with our own ready keeps WAIT/ERR1 from accepting even if HREADY is forced high.
    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & r_hreadyout;

    assign w_out_of_range = ({1'b0, bus.HADDR} < LO_ADDR) || ({1'b0, bus.HADDR} >= HI_ADDR);
    assign w_bad_size     = bus.HSIZE > 3'(LANE_W);

`ifdef AHB_MEM_SLAVE_ALIGN_CHK_EN
    logic [ADDR_W-1:0] w_size_mask;
    assign w_size_mask = ADDR_W'((64'd1 << bus.HSIZE) - 64'd1);
    assign w_err = w_out_of_range | w_bad_size | (|(bus.HADDR & w_size_mask));
`else
    assign w_err = w_out_of_range | w_bad_size;
`endif

    assign w_unused = &{1'b0, bus.HBURST, bus.HTRANS[0]};

    // Misaligned addresses are aligned down to the transfer size.
    assign w_lane_lo = r_addr[LANE_W-1:0] & ~LANE_W'((32'd1 << r_size) - 32'd1);
    assign w_idx     = IDX_W'((r_addr - ADDR_W'(BASE_ADDR)) >> LANE_W);

    always_comb begin
        w_be = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_be[b] = (b >= int'(w_lane_lo)) && (b < int'(w_lane_lo) + (1 << r_size));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_size      <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.HADDR;
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
            end
            case (r_state)
                S_WAIT: begin
                    if (r_wait_cnt <= 4'd1) begin
                        r_state     <= S_DATA;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 2'b01;
                end
                default: begin
                    if (w_accept && w_err) begin
                        r_state     <= S_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 2'b01;
                    end else if (w_accept && (WAIT_STATES > 0)) begin
                        r_state     <= S_WAIT;
                        r_wait_cnt  <= 4'(WAIT_STATES);
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 2'b00;
                    end else if (w_accept) begin
                        r_state     <= S_DATA;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 2'b00;
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 2'b00;
                    end
                end
            endcase
        end
    end

    // Memory is not reset; a data phase interrupted by reset never commits.
    always_ff @(posedge clk) begin
        if (resetn && (r_state == S_DATA) && r_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = ((r_state == S_DATA) && !r_write) ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: dut0 has zero wait states, dut2 has two; both share master drive signals.
`timescale 1ns/1ps
module tb_ahb_mem_slave;
    logic        clk = 1'b0;
    logic        resetn;
    logic        hsel0, hsel2;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.HSEL   = hsel0;
    assign bus0.HADDR  = haddr;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HBURST = hburst;
    assign bus0.HTRANS = htrans;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus2.HSEL   = hsel2;
    assign bus2.HADDR  = haddr;
    assign bus2.HWRITE = hwrite;
    assign bus2.HSIZE  = hsize;
    assign bus2.HBURST = hburst;
    assign bus2.HTRANS = htrans;
    assign bus2.HWDATA = hwdata;
    assign bus2.HREADY = bus2.HREADYOUT;

    ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0))
        dut0 (.clk(clk), .resetn(resetn), .bus(bus0.slave));
    ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2))
        dut2 (.clk(clk), .resetn(resetn), .bus(bus2.slave));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_of(input bit w);
        return w ? bus2.HREADYOUT : bus0.HREADYOUT;
    endfunction

    function automatic logic [1:0] resp_of(input bit w);
        return w ? bus2.HRESP : bus0.HRESP;
    endfunction

    function automatic logic [31:0] rdata_of(input bit w);
        return w ? bus2.HRDATA : bus0.HRDATA;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single transfer starting from an idle slave; returns data/response of the data phase.
    task automatic xfer(input bit w, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] resp_first, output logic [1:0] resp_last, output int waits);
        hsel0 = !w; hsel2 = w; haddr = a; hwrite = wr; hsize = sz; hburst = 3'b000; htrans = 2'b10;
        step();
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        resp_first = resp_of(w);
        while (!rdy_of(w) && waits < 40) begin
            waits++;
            step();
        end
        rd = rdata_of(w);
        resp_last = resp_of(w);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rf, rl;
        int          wt, nb, done, dcyc;

        resetn = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'b000; htrans = 2'b00; hwdata = '0;
        repeat (2) step();
        resetn = 1'b1;
        check_val("rst_rdy", bus0.HREADYOUT, 1);
        check_val("rst_resp", bus0.HRESP, 0);
        check_val("rst_rdata", bus0.HRDATA, 0);

        // Back-to-back write then read of the same word
        hsel0 = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        step();
        check_val("b2b_wr_rdy", bus0.HREADYOUT, 1);
        hwdata = 32'hDEADBEEF; hwrite = 1'b0; htrans = 2'b10;
        step();
        check_val("b2b_rd_rdy", bus0.HREADYOUT, 1);
        check_val("b2b_rd_data", bus0.HRDATA, 32'hDEADBEEF);
        hsel0 = 1'b0; htrans = 2'b00;
        step();
        check_val("idle_rdata", bus0.HRDATA, 0);

        // Byte and halfword lane writes
        xfer(0, 1, 32'h10, 3'd2, 32'h11223344, rd, rf, rl, wt);
        xfer(0, 1, 32'h13, 3'd0, 32'hAA000000, rd, rf, rl, wt);
        xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("byte3_data", rd, 32'hAA223344);
        check_val("byte3_resp", rl, 0);
        check_val("zero_wait", wt, 0);
        xfer(0, 1, 32'h14, 3'd2, 32'h01020304, rd, rf, rl, wt);
        xfer(0, 1, 32'h16, 3'd1, 32'h55660000, rd, rf, rl, wt);
        xfer(0, 1, 32'h15, 3'd0, 32'h0000EE00, rd, rf, rl, wt);
        xfer(0, 0, 32'h14, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("half_byte_data", rd, 32'h5566EE04);

        // Wait states on dut2: single read then 4-beat INCR burst
        for (int i = 0; i < 4; i++)
            xfer(1, 1, 32'h40 + 32'(4*i), 3'd2, 32'hA0000000 | 32'(i), rd, rf, rl, wt);
        xfer(1, 0, 32'h44, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("ws_waits", wt, 2);
        check_val("ws_data", rd, 32'hA0000001);
        check_val("ws_resp", rl, 0);

        hsel2 = 1'b1; haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2; hburst = 3'b011; htrans = 2'b10;
        nb = 1; done = 0; dcyc = 0;
        step();
        while (done < 4 && dcyc < 100) begin
            dcyc++;
            if (bus2.HREADYOUT) begin
                check_val($sformatf("burst_d%0d", done), bus2.HRDATA, 32'hA0000000 | 32'(done));
                done++;
                if (nb < 4) begin
                    haddr = 32'h40 + 32'(4*nb); htrans = 2'b11; nb++;
                end else begin
                    hsel2 = 1'b0; htrans = 2'b00; hburst = 3'b000;
                end
            end
            step();
        end
        check_val("burst_cycles", dcyc, 12);

        // Reset in the middle of a waited write drops it
        xfer(1, 1, 32'h20, 3'd2, 32'h00001234, rd, rf, rl, wt);
        hsel2 = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        step();
        check_val("mid_wait_rdy", bus2.HREADYOUT, 0);
        hsel2 = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF; resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        check_val("rst2_rdy", bus2.HREADYOUT, 1);
        check_val("rst2_resp", bus2.HRESP, 0);
        check_val("rst2_rdata", bus2.HRDATA, 0);
        xfer(1, 0, 32'h20, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("rst2_mem", rd, 32'h00001234);

        // Out-of-range and oversize accesses
        xfer(0, 1, 32'h0, 3'd2, 32'hCAFEF00D, rd, rf, rl, wt);
        xfer(0, 0, 32'h400, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("oor_resp1", rf, 1);
        check_val("oor_resp2", rl, 1);
        check_val("oor_waits", wt, 1);
        check_val("oor_rdata", rd, 0);
        xfer(0, 1, 32'h400, 3'd2, 32'h0BADBAD0, rd, rf, rl, wt);
        check_val("oor_wr_resp", rl, 1);
        xfer(0, 0, 32'h0, 3'd3, 32'h0, rd, rf, rl, wt);
        check_val("dword_resp", rl, 1);
        xfer(1, 0, 32'h400, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("oor_ws_waits", wt, 1);
        xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("oor_wr_kept", rd, 32'hCAFEF00D);

        // IDLE, BUSY and deselected transfers are zero-wait OKAY and do nothing
        hsel0 = 1'b1; htrans = 2'b00;
        step();
        check_val("idle_rdy", bus0.HREADYOUT, 1);
        check_val("idle_resp", bus0.HRESP, 0);
        htrans = 2'b01;
        step();
        check_val("busy_rdy", bus0.HREADYOUT, 1);
        check_val("busy_resp", bus0.HRESP, 0);
        hsel0 = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0;
        step();
        hwdata = 32'hFFFFFFFF; htrans = 2'b00;
        check_val("nosel_rdy", bus0.HREADYOUT, 1);
        check_val("nosel_resp", bus0.HRESP, 0);
        step();
        xfer(0, 0, 32'h0, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("nosel_kept", rd, 32'hCAFEF00D);

        // Misaligned word access at 0x12
        xfer(0, 0, 32'h12, 3'd2, 32'h0, rd, rf, rl, wt);
`ifdef AHB_MEM_SLAVE_ALIGN_CHK_EN
        check_val("mis_resp", rl, 1);
        check_val("mis_waits", wt, 1);
        xfer(0, 1, 32'h12, 3'd2, 32'h55555555, rd, rf, rl, wt);
        xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("mis_wr_kept", rd, 32'hAA223344);
`else
        check_val("mis_resp", rl, 0);
        check_val("mis_waits", wt, 0);
        check_val("mis_data", rd, 32'hAA223344);
        xfer(0, 1, 32'h12, 3'd2, 32'h55555555, rd, rf, rl, wt);
        xfer(0, 0, 32'h10, 3'd2, 32'h0, rd, rf, rl, wt);
        check_val("mis_wr_data", rd, 32'h55555555);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Parametrised AHB slave holding a byte-addressable memory; the synthesizable target behind the bench's AHB interface.
- Generalises the bus to DATA_W 32/64 and adds configurable wait states, byte-lane writes, and two-cycle ERROR responses.
- Sits on the AHB side of the AHB2APB bridge environment as a reference slave for bridge and master bring-up.

Parameters:
ADDR_W, 32, HADDR width.
DATA_W, 32, HWDATA/HRDATA width; legal values 32 or 64.
DEPTH, 256, memory depth in DATA_W-wide words.
BASE_ADDR, 32'h0000_0000, first byte address decoded; must be aligned to DATA_W/8.
WAIT_STATES, 0, HREADYOUT-low cycles inserted before every OKAY data phase; range 0..15.

Ports:
clk  in  1  clock; all state changes on posedge.
resetn  in  1  synchronous active-low reset.
HSEL  in  1  slave select.
HADDR  in  ADDR_W  byte address (address phase).
HWRITE  in  1  1=write, 0=read (address phase).
HSIZE  in  3  transfer size: 0 byte, 1 half, 2 word, 3 dword.
HBURST  in  3  burst type; accepted, does not affect behaviour.
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HWDATA  in  DATA_W  write data (data phase).
HREADY  in  1  bus-level ready; address phase is sampled only when high.
HREADYOUT  out  1  slave ready.
HRESP  out  2  00 OKAY, 01 ERROR; 10/11 never driven.
HRDATA  out  DATA_W  read data.

Behaviour:
- Reset (resetn=0 at posedge): FSM to IDLE; HREADYOUT=1, HRESP=00, HRDATA=0; any pending data phase dropped, no write committed. Memory contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at posedge.
  - Registers addr_q, write_q, size_q.
  - Computes err_q: out of range (HADDR<BASE_ADDR or HADDR>=BASE_ADDR+DEPTH*DATA_W/8) or HSIZE>log2(DATA_W/8).
- IDLE/BUSY, HSEL=0 or HREADY=0: no transfer; slave returns/stays OKAY, HREADYOUT=1, zero wait.
- FSM states IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE -> ERR1 on accept with err.
  - IDLE -> WAIT on accept with WAIT_STATES>0; load counter = WAIT_STATES.
  - IDLE -> DATA on accept with WAIT_STATES=0.
  - WAIT: HREADYOUT=0, HRESP=00; decrement each cycle; go to DATA when counter reaches 1.
  - DATA: HREADYOUT=1, HRESP=00.
    - Read: HRDATA = mem word at addr_q (combinational array read), all lanes driven.
    - Write: HWDATA lanes selected by size_q and addr_q low bits are written at the posedge ending DATA. Little-endian; lane = addr_q[log2(DATA_W/8)-1:0] .. + 2^size_q - 1.
    - A new accept in the same cycle (pipelined) goes directly to WAIT, DATA or ERR1; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=01. ERR2: HREADYOUT=1, HRESP=01; no write; HRDATA=0. A master that cancels with IDLE during ERR2 is not accepted (HREADY=0 in ERR1 blocks accept). ERR2 -> IDLE, or to next state if accepted.
- HRDATA=0 whenever not in a read DATA cycle.
- Write-then-read to the same address back-to-back: the read returns the newly written data. The write commits at the edge ending the write DATA phase, before the read's DATA phase.
- Latency: single transfer data phase completes WAIT_STATES+1 cycles after address accept.

Optional Feature:
- Macro AHB_MEM_SLAVE_ALIGN_CHK_EN.
- Defined: HADDR not a multiple of 2^HSIZE sets err (ERROR response, write suppressed).
- Undefined: low HADDR bits below HSIZE are ignored; access is aligned down, OKAY.

Test Plan:
1. Reset with resetn=0 for 2 cycles mid-WAIT -> next cycle HREADYOUT=1, HRESP=00, HRDATA=0, no memory write.
2. DATA_W=32, WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF, then NONSEQ read 0x10 back-to-back -> read data phase HRDATA=0xDEADBEEF, HREADYOUT=1 throughout.
3. Byte write HSIZE=0 to 0x13 data 0xAA000000 onto word 0x11223344 -> read 0x10 returns 0xAA223344.
4. WAIT_STATES=2 read -> HREADYOUT low exactly 2 cycles then high with data; 4-beat INCR SEQ burst completes in 12 data cycles.
5. Read at BASE_ADDR+DEPTH*4 -> HRESP=01 with HREADYOUT=0 then 1; a write there leaves memory unchanged; IDLE/BUSY and HSEL=0 -> OKAY zero-wait.
6. With AHB_MEM_SLAVE_ALIGN_CHK_EN, HSIZE=2 at 0x12 -> two-cycle ERROR. Without the macro -> OKAY, access to word 0x10.
